// File: rtl/stim_seq_pkg.sv
// stim_seq_pkg: shared state enum, default operand pattern and LFSR tap masks for stim_sequencer
package stim_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, DONE} state_e;
  localparam logic [31:0] PATTERN_DEF = 32'h5555_5555;
  function automatic logic [31:0] lfsr_mask(input int w);
    return w == 8 ? 32'h0000_00B8 : w == 16 ? 32'h0000_B400 : 32'h8020_0003;
  endfunction
endpackage

// File: rtl/stim_seq_if.sv
// stim_seq_if: run/handshake/status bundle between stim_sequencer (master) and its user (slave)
interface stim_seq_if #(parameter int WIDTH = 8, parameter int LENGTH = 6);
  localparam int CW = $clog2(LENGTH + 1);
  logic run, ready, start, busy, done;
  logic [WIDTH-1:0] result, x, result_xor;
  logic [CW-1:0] vec_count, timeout_count;
  modport master (input run, ready, result, output start, x, busy, done, vec_count, timeout_count, result_xor);
  modport slave (output run, ready, result, input start, x, busy, done, vec_count, timeout_count, result_xor);
endinterface

// File: rtl/stim_lfsr.sv
// stim_lfsr: WIDTH-bit right-shifting Galois LFSR; nxt is the state after one step
module stim_lfsr import stim_seq_pkg::*; #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  output logic [WIDTH-1:0] nxt
);
  localparam logic [WIDTH-1:0] MASK = WIDTH'(lfsr_mask(WIDTH));
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  always_comb begin
    nxt = (lfsr_q >> 1) ^ (lfsr_q[0] ? MASK : '0);
    lfsr_d = load ? SEED : step ? nxt : lfsr_q;
  end
  always_ff @(posedge clock) lfsr_q <= reset ? SEED : lfsr_d;
endmodule

// File: rtl/stim_sequencer.sv
// stim_sequencer: batch operand/start/ready sequencer with timeout and checksum; STIM_SEQ_LFSR_EN selects LFSR operands
module stim_sequencer import stim_seq_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int LENGTH = 6,
  parameter int TIMEOUT = 16,
  parameter logic [WIDTH-1:0] PATTERN = PATTERN_DEF[WIDTH-1:0],
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
  input logic        clock,
  input logic        reset,
  stim_seq_if.master io
);
  localparam int CW = $clog2(LENGTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  state_e state_q, state_d;
  logic [TW-1:0] wait_q, wait_d;
  logic [WIDTH-1:0] x_q, x_d, xor_q, xor_d, gen_val;
  logic [CW-1:0] vec_q, vec_d, to_q, to_d;
  logic gen_load, gen_step, hit, tmo;
`ifdef STIM_SEQ_LFSR_EN
  stim_lfsr #(.WIDTH(WIDTH), .SEED(SEED)) u_lfsr (
    .clock(clock), .reset(reset), .load(gen_load), .step(gen_step), .nxt(gen_val)
  );
`else
  logic [WIDTH-1:0] pat_q, pat_d;
  assign gen_val = pat_q;
  always_comb pat_d = gen_load ? PATTERN : gen_step ? {pat_q[WIDTH-2:0], pat_q[WIDTH-1]} : pat_q;
  always_ff @(posedge clock) pat_q <= reset ? PATTERN : pat_d;
`endif
  // ready is a level, so the first WAIT cycle may still see the previous vector's ready
  assign hit = state_q == WAIT && io.ready && wait_q != '0;
  assign tmo = state_q == WAIT && !hit && wait_q == TW'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    x_d = x_q;
    vec_d = vec_q;
    to_d = to_q;
    xor_d = xor_q;
    gen_load = 1'b0;
    gen_step = 1'b0;
    case (state_q)
      IDLE: if (io.run) begin
        vec_d = '0;
        to_d = '0;
        xor_d = '0;
        gen_load = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        x_d = gen_val;
        gen_step = 1'b1;
        state_d = START;
      end
      START: begin
        wait_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wait_d = wait_q + 1'b1;
        xor_d = hit ? xor_q ^ io.result : xor_q;
        vec_d = (hit || tmo) ? vec_q + 1'b1 : vec_q;
        to_d = to_q + CW'(tmo);
        state_d = (hit || tmo) ? ((int'(vec_q) + 1 < LENGTH) ? LOAD : DONE) : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      wait_q <= '0;
      x_q <= '0;
      vec_q <= '0;
      to_q <= '0;
      xor_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      x_q <= x_d;
      vec_q <= vec_d;
      to_q <= to_d;
      xor_q <= xor_d;
    end
  end
  assign io.start = state_q == START;
  assign io.busy = state_q != IDLE;
  assign io.done = state_q == DONE;
  assign io.x = x_q;
  assign io.vec_count = vec_q;
  assign io.timeout_count = to_q;
  assign io.result_xor = xor_q;
endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: directed bench for stim_sequencer with a latency-3 / never-ready / always-ready DUT model
module tb_stim_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int mode = 0;
  int cnt = 0;
  int nstart, ndone, cdone;
  logic [7:0] xs [0:15];
  logic [7:0] exp_x [0:5];
  logic [7:0] exp_xor;
  always #5 clk = ~clk;
  stim_seq_if #(.WIDTH(8), .LENGTH(6)) bus ();
  stim_sequencer #(.WIDTH(8), .LENGTH(6), .TIMEOUT(16), .PATTERN(8'h55), .SEED(8'h01)) dut (
    .clock(clk), .reset(rst), .io(bus)
  );
  always @(posedge clk) cnt <= bus.start ? 1 : (cnt != 0 && cnt < 3) ? cnt + 1 : cnt;
  assign bus.ready = mode == 2 || (mode == 0 && cnt >= 3);
  assign bus.result = bus.x ^ 8'hFF;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, bus.start, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_x"}, bus.x, 0);
    chk({tag, "_vec"}, bus.vec_count, 0);
    chk({tag, "_to"}, bus.timeout_count, 0);
    chk({tag, "_xor"}, bus.result_xor, 0);
  endtask
  task automatic run_batch(input int poke);
    nstart = 0;
    ndone = 0;
    cdone = 0;
    @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    for (int c = 1; c < 300; c++) begin
      bus.run = (c == poke);
      if (bus.start) begin
        if (nstart < 16) xs[nstart] = bus.x;
        nstart++;
      end
      if (bus.done) begin
        ndone++;
        cdone = c;
      end
      if (!bus.busy) break;
      @(negedge clk);
    end
    bus.run = 1'b0;
    chk("batch_idle", bus.busy, 0);
  endtask
  initial begin
`ifdef STIM_SEQ_LFSR_EN
    exp_x = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1};
`else
    exp_x = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA};
`endif
    exp_xor = 8'h00;
    for (int i = 0; i < 6; i++) exp_xor ^= exp_x[i] ^ 8'hFF;
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("rst_run");
    rst = 1'b0;
    bus.run = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", bus.busy, 0);
    mode = 0;
    run_batch(10);
    for (int i = 0; i < 6; i++) chk($sformatf("lat3_x%0d", i), xs[i], exp_x[i]);
    chk("lat3_nstart", nstart, 6);
    chk("lat3_ndone", ndone, 1);
    chk("lat3_done_cycle", cdone, 31);
    chk("lat3_vec", bus.vec_count, 6);
    chk("lat3_to", bus.timeout_count, 0);
    chk("lat3_xor", bus.result_xor, exp_xor);
    repeat (3) @(negedge clk);
    chk("hold_vec", bus.vec_count, 6);
    chk("hold_xor", bus.result_xor, exp_xor);
    mode = 1;
    run_batch(0);
    chk("tmo_ndone", ndone, 1);
    chk("tmo_done_cycle", cdone, 109);
    chk("tmo_vec", bus.vec_count, 6);
    chk("tmo_to", bus.timeout_count, 6);
    chk("tmo_xor", bus.result_xor, 0);
    mode = 2;
    run_batch(0);
    chk("hi_done_cycle", cdone, 25);
    chk("hi_vec", bus.vec_count, 6);
    chk("hi_to", bus.timeout_count, 0);
    chk("hi_xor", bus.result_xor, exp_xor);
    mode = 0;
    @(negedge clk);
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
    nstart = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.start) nstart++;
      if (nstart == 3) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk("mid_vec_before", bus.vec_count, 2);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("mid_rst");
    rst = 1'b0;
    run_batch(0);
    chk("rerun_x0", xs[0], exp_x[0]);
    chk("rerun_x1", xs[1], exp_x[1]);
    chk("rerun_done_cycle", cdone, 31);
    chk("rerun_vec", bus.vec_count, 6);
    chk("rerun_to", bus.timeout_count, 0);
    chk("rerun_xor", bus.result_xor, exp_xor);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stim_sequencer.md
# stim_sequencer

Synthesizable stimulus and handshake sequencer for start/ready compute blocks. Replaces the simulation-only stimulus loop, so the same vector sequencing runs on the Quartus target. It issues LENGTH operand vectors to a DUT, pulses `start`, waits for `ready` with a timeout, and captures each result into running counters and a checksum. It sits beside the DUT and shares the DUT's `clock`/`reset`.

## Interface
- `WIDTH`, 8 — operand/result width; 8, 16 or 32.
- `LENGTH`, 6 — vectors per batch; must be ≥1.
- `TIMEOUT`, 16 — max WAIT cycles per vector; must be ≥2.
- `PATTERN`, 8'h55 (alternating 01, extended to WIDTH) — base operand in pattern mode.
- `SEED`, 1 — LFSR seed in LFSR mode; must be nonzero.

Ports:
- `clock` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `run` in 1 — batch start request; sampled in IDLE only.
- `ready` in 1 — DUT completion, level.
- `result` in WIDTH — DUT output, valid while `ready`=1.
- `start` out 1 — one-cycle pulse to DUT.
- `x` out WIDTH — operand to DUT, stable from LOAD until next LOAD.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse at batch end.
- `vec_count` out $clog2(LENGTH+1) — vectors finished (ok + timed out).
- `timeout_count` out $clog2(LENGTH+1) — vectors that timed out.
- `result_xor` out WIDTH — XOR of all captured results.

## Operation
- States: IDLE, LOAD, START, WAIT, DONE.
- IDLE, `run`=1: clear `vec_count`, `timeout_count` and `result_xor`; reload the operand generator; go to LOAD.
- LOAD (1 cycle): `x` ← next operand; go to START.
- START (1 cycle): `start`=1; clear wait counter; go to WAIT.
- WAIT: `wait_cnt` increments each cycle.
  - `ready` is masked while `wait_cnt`==0. This guards against stale level ready from the previous vector.
  - `ready`=1 with `wait_cnt`≥1: `result_xor` ^= `result`; `vec_count`++.
  - No ready and `wait_cnt`==TIMEOUT-1: `timeout_count`++; `vec_count`++; result is not captured.
  - After either event: go to LOAD if `vec_count`+1 < LENGTH, else go to DONE.
- DONE (1 cycle): `done`=1; go to IDLE. Counters and checksum hold until the next `run` or `reset`.
- `run` is ignored while `busy`=1.
- Operand generation (pattern mode): vector i gets PATTERN rotated left by i mod WIDTH. Example for WIDTH=8: 55, AA, 55, …
- Counters saturate only by construction; `vec_count` never exceeds LENGTH.

## Timing
- Reset value of every output is 0, including `x`. Generator state returns to PATTERN or SEED; state returns to IDLE.
- `reset` and `run` on the same edge: reset wins.
- Reset mid-batch: same as a power-on reset. `start` is 0 the following cycle, and no partial result is kept.
- `run` seen at edge k: LOAD during k+1, `start` high during k+2.
- Per vector: 2 + L cycles, where ready is first seen in WAIT cycle L (L ≥ 2). A timed-out vector takes 2 + TIMEOUT cycles.
- `done` follows the last vector's WAIT exit by one cycle; IDLE is reached one cycle later.
- DUT contract: ready must drop within one cycle of `start`.

## Configuration
- `STIM_SEQ_LFSR_EN` defined: the operand is the next state of a WIDTH-bit Galois LFSR.
  - Right shift; XOR the tap mask when the shifted-out LSB is 1.
  - Masks: 8'hB8, 16'hB400, 32'h80200003.
  - The generator starts at SEED; the first `x` is SEED stepped once.
- Undefined: rotated-PATTERN mode as above; the LFSR logic is absent.

## Structure
- Package `stim_seq_pkg`:
  - state enum;
  - LFSR tap mask function keyed by WIDTH;
  - default PATTERN constant.
- One sub-module, `stim_lfsr` (WIDTH, SEED; `load`/`step` inputs), instantiated only under `STIM_SEQ_LFSR_EN`.
- The FSM, wait counter, result counters and checksum live in `stim_sequencer`.

## Test plan
- Reset with `run`=1 on the same edge → all outputs 0; state stays IDLE; no `start`.
- Pattern mode, WIDTH=8, LENGTH=6, DUT latency 3, result = x^8'hFF:
  - `x` = 55, AA, 55, AA, 55, AA;
  - `done` 31 cycles after `run`;
  - `vec_count`=6, `timeout_count`=0, `result_xor`=8'hFF.
- DUT never ready, TIMEOUT=16 → each vector 18 cycles; `timeout_count`=6; `result_xor`=0; single `done` pulse.
- `ready` held constantly high → first WAIT cycle masked, capture in the second; 4 cycles per vector; `vec_count`=6.
- `reset` during WAIT of vector 3 → next cycle all outputs 0. A new `run` restarts with `x`=55 and counters from 0.
- `STIM_SEQ_LFSR_EN`, SEED=8'h01 → `x` = B8, 5C, 2E, 17, B3, E1. A `run` during `busy` is ignored: still 6 vectors and one `done`.
